// File: rtl/riscv_pkg.sv
// riscv_pkg: shared LSU state encoding and RV32I load/store width codes
package riscv_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} lsu_state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational request formatting and load data extraction
// Ports:
//   i_we, i_f3, i_addr_lo, i_wdata -> o_ok (legal and aligned), o_be, o_wdata
//   i_ld_f3, i_ld_addr_lo, i_rdata -> o_rdata (shifted and extended load data)
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_f3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic        o_ok,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);
    logic        w_legal;
    logic        w_aligned;
    logic [31:0] w_shift;

    // Stores have no unsigned variants, so BU/HU codes are only legal for loads.
    assign w_legal   = (i_f3 == F3_B) || (i_f3 == F3_H) || (i_f3 == F3_W) ||
                       (!i_we && ((i_f3 == F3_BU) || (i_f3 == F3_HU)));
    assign w_aligned = (i_f3[1:0] == 2'b00) ||
                       (i_f3[1:0] == 2'b01 && !i_addr_lo[0]) ||
                       (i_f3[1:0] == 2'b10 && i_addr_lo == 2'b00);
    assign o_ok      = w_legal && w_aligned;

    assign o_be    = (i_f3[1:0] == 2'b10) ? 4'b1111 :
                     (i_f3[1:0] == 2'b01) ? 4'b0011 << i_addr_lo : 4'b0001 << i_addr_lo;
    assign o_wdata = (i_f3[1:0] == 2'b10) ? i_wdata :
                     (i_f3[1:0] == 2'b01) ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};

    assign w_shift = i_rdata >> {i_ld_addr_lo, 3'b000};
    assign o_rdata = (i_ld_f3 == F3_B)  ? {{24{w_shift[7]}}, w_shift[7:0]} :
                     (i_ld_f3 == F3_H)  ? {{16{w_shift[15]}}, w_shift[15:0]} :
                     (i_ld_f3 == F3_BU) ? {24'b0, w_shift[7:0]} :
                     (i_ld_f3 == F3_HU) ? {16'b0, w_shift[15:0]} : i_rdata;
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between execute stage and data memory
// Ports:
//   req_*  : op handshake from execute; req_ready high only while IDLE
//   mem_*  : word-aligned request held until mem_gnt, load data on mem_rvalid
//   resp_* : registered one-cycle load result with destination register
//   err_misalign : one-cycle pulse when a misaligned/illegal op is dropped
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic [4:0]        resp_rd,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              err_misalign
);
    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [XLEN-1:0]   r_wdata;
    logic [4:0]        r_rd;
    logic              r_resp_valid;
    logic [4:0]        r_resp_rd;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_err;
    logic              w_accept;
    logic              w_ok;
    logic              w_resp;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rdata;

    riscv_lsu_align u_align (
        .i_we         (req_we),
        .i_f3         (req_funct3),
        .i_addr_lo    (req_addr[1:0]),
        .i_wdata      (req_wdata),
        .o_ok         (w_ok),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .i_ld_f3      (r_f3),
        .i_ld_addr_lo (r_addr[1:0]),
        .i_rdata      (mem_rdata),
        .o_rdata      (w_rdata)
    );

    assign w_accept = req_valid && (r_state == IDLE);
    // A load completes either on rvalid in WAIT or when data returns alongside the grant.
    assign w_resp   = (r_state == ISSUE && mem_gnt && !r_we && mem_rvalid) ||
                      (r_state == WAIT && mem_rvalid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_accept && w_ok) ? ISSUE : IDLE;
            ISSUE:   w_next = !mem_gnt ? ISSUE : (r_we || mem_rvalid) ? IDLE : WAIT;
            WAIT:    w_next = mem_rvalid ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we         <= 1'b0;
            r_f3         <= 3'b0;
            r_addr       <= '0;
            r_be         <= 4'b0;
            r_wdata      <= '0;
            r_rd         <= 5'b0;
            r_resp_valid <= 1'b0;
            r_resp_rd    <= 5'b0;
            r_resp_rdata <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err        <= w_accept && !w_ok;
            r_resp_valid <= w_resp;
            if (w_accept && w_ok) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_rd    <= req_rd;
            end
            if (w_resp) begin
                r_resp_rd    <= r_rd;
                r_resp_rdata <= w_rdata;
            end
        end
    end

    // Derived from the state register so the request drops as soon as reset asserts.
    assign mem_req      = (r_state == ISSUE);
    assign req_ready    = (r_state == IDLE);
    assign mem_we       = r_we;
    assign mem_be       = r_be;
    assign mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata    = r_wdata;
    assign resp_valid   = r_resp_valid;
    assign resp_rd      = r_resp_rd;
    assign resp_rdata   = r_resp_rdata;
    assign err_misalign = r_err;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed self-checking bench for riscv_lsu
module tb_riscv_lsu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rdata;
    logic        err_misalign;
    int checks = 0;
    int errors = 0;

    riscv_lsu dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_rdata(resp_rdata),
        .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    endtask

    // Load with grant, then rvalid one cycle later; called and returns on a falling edge.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] rdata, output logic [3:0] be,
                            output logic v, output logic [4:0] rrd, output logic [31:0] data);
        drive_req(0, f3, addr, 0, rd);
        @(negedge clk);
        be = mem_be;
        req_valid = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 0;
        v = resp_valid; rrd = resp_rd; data = resp_rdata;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset_n = 0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if ({mem_we, mem_be, resp_valid, err_misalign} !== 7'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {mem_we, mem_be, resp_valid, err_misalign}); end
        checks++; if ({mem_addr, mem_wdata, resp_rd, resp_rdata} !== 101'b0) begin errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, resp_rd, resp_rdata}); end
        reset_n = 1;
    endtask

    task automatic test_lw;
        drive_req(0, 3'b010, 32'h10, 0, 5'd5);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lw_ready_idle got %b exp 1", req_ready); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lw_mem_req got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL lw_addr got %h exp 00000010", mem_addr); end
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL lw_be got %b exp 1111", mem_be); end
        checks++; if ({mem_we, req_ready} !== 2'b00) begin errors++; $display("FAIL lw_we_ready got %b exp 00", {mem_we, req_ready}); end
        req_valid = 0; mem_gnt = 1;
        @(negedge clk);
        checks++; if ({mem_req, req_ready, resp_valid} !== 3'b000) begin errors++; $display("FAIL lw_wait got %b exp 000", {mem_req, req_ready, resp_valid}); end
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h4;
        @(negedge clk);
        mem_rvalid = 0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lw_resp_valid got %b exp 1", resp_valid); end
        checks++; if (resp_rd !== 5'd5) begin errors++; $display("FAIL lw_resp_rd got %0d exp 5", resp_rd); end
        checks++; if (resp_rdata !== 32'h4) begin errors++; $display("FAIL lw_resp_rdata got %h exp 00000004", resp_rdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lw_ready_back got %b exp 1", req_ready); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lw_resp_pulse got %b exp 0", resp_valid); end
    endtask

    task automatic test_load_extend;
        logic [3:0]  be;
        logic        v;
        logic [4:0]  rrd;
        logic [31:0] d;
        run_load(3'b000, 32'h13, 5'd7, 32'h80112233, be, v, rrd, d);
        checks++; if (be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", be); end
        checks++; if ({v, rrd} !== {1'b1, 5'd7}) begin errors++; $display("FAIL lb_resp got %b_%0d exp 1_7", v, rrd); end
        checks++; if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", d); end
        run_load(3'b100, 32'h13, 5'd7, 32'h80112233, be, v, rrd, d);
        checks++; if (d !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", d); end
        run_load(3'b001, 32'h12, 5'd8, 32'h80012233, be, v, rrd, d);
        checks++; if (be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b exp 1100", be); end
        checks++; if (d !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", d); end
        run_load(3'b101, 32'h12, 5'd8, 32'h80012233, be, v, rrd, d);
        checks++; if (d !== 32'h00008001) begin errors++; $display("FAIL lhu_data got %h exp 00008001", d); end
        run_load(3'b000, 32'h11, 5'd9, 32'h11223344, be, v, rrd, d);
        checks++; if (d !== 32'h00000033) begin errors++; $display("FAIL lb_pos_data got %h exp 00000033", d); end
    endtask

    task automatic test_sh;
        drive_req(1, 3'b001, 32'h06, 32'h1234ABCD, 5'd0);
        @(negedge clk);
        checks++; if (mem_addr !== 32'h04) begin errors++; $display("FAIL sh_addr got %h exp 00000004", mem_addr); end
        checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", mem_be); end
        checks++; if (mem_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcd", mem_wdata); end
        checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL sh_req_we got %b exp 11", {mem_req, mem_we}); end
        req_valid = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        checks++; if ({mem_req, req_ready, resp_valid} !== 3'b010) begin errors++; $display("FAIL sh_done got %b exp 010", {mem_req, req_ready, resp_valid}); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sh_no_resp got %b exp 0", resp_valid); end
    endtask

    task automatic test_misalign;
        logic [35:0] tbl [5];
        tbl[0] = {1'b0, 3'b010, 32'h02};
        tbl[1] = {1'b0, 3'b001, 32'h05};
        tbl[2] = {1'b1, 3'b010, 32'h01};
        tbl[3] = {1'b1, 3'b100, 32'h00};
        tbl[4] = {1'b0, 3'b110, 32'h00};
        for (int i = 0; i < 5; i++) begin
            drive_req(tbl[i][35], tbl[i][34:32], tbl[i][31:0], 32'hFFFF_FFFF, 5'd3);
            @(negedge clk);
            req_valid = 0;
            checks++; if ({err_misalign, mem_req, req_ready} !== 3'b101) begin errors++; $display("FAIL misalign_%0d got %b exp 101", i, {err_misalign, mem_req, req_ready}); end
            @(negedge clk);
            checks++; if ({err_misalign, mem_req, req_ready} !== 3'b001) begin errors++; $display("FAIL misalign_after_%0d got %b exp 001", i, {err_misalign, mem_req, req_ready}); end
        end
    endtask

    task automatic test_gnt_stall;
        drive_req(0, 3'b010, 32'h20, 0, 5'd9);
        @(negedge clk);
        req_valid = 0;
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({mem_req, req_ready, resp_valid} !== 3'b100) begin errors++; $display("FAIL stall_ctrl_%0d got %b exp 100", i, {mem_req, req_ready, resp_valid}); end
            checks++; if ({mem_addr, mem_be} !== {32'h20, 4'b1111}) begin errors++; $display("FAIL stall_addr_be_%0d got %h exp 00000020f", i, {mem_addr, mem_be}); end
            if (i < 2) @(negedge clk);
        end
        mem_gnt = 1; mem_rdata = 32'h11223344;
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0;
        checks++; if ({resp_valid, resp_rd} !== {1'b1, 5'd9}) begin errors++; $display("FAIL gnt_rvalid_resp got %b_%0d exp 1_9", resp_valid, resp_rd); end
        checks++; if (resp_rdata !== 32'h11223344) begin errors++; $display("FAIL gnt_rvalid_data got %h exp 11223344", resp_rdata); end
        checks++; if ({mem_req, req_ready} !== 2'b01) begin errors++; $display("FAIL gnt_rvalid_idle got %b exp 01", {mem_req, req_ready}); end
    endtask

    task automatic test_reset_mid;
        drive_req(0, 3'b010, 32'h30, 0, 5'd3);
        @(negedge clk);
        req_valid = 0;
        reset_n = 0;
        #1;
        checks++; if ({mem_req, req_ready} !== 2'b01) begin errors++; $display("FAIL rst_issue got %b exp 01", {mem_req, req_ready}); end
        @(negedge clk);
        reset_n = 1;
        drive_req(0, 3'b010, 32'h30, 0, 5'd3);
        @(negedge clk);
        req_valid = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_wait got %b exp 0", req_ready); end
        reset_n = 0;
        #1;
        checks++; if ({mem_req, req_ready} !== 2'b01) begin errors++; $display("FAIL rst_wait got %b exp 01", {mem_req, req_ready}); end
        @(negedge clk);
        reset_n = 1;
        mem_rvalid = 1; mem_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        mem_rvalid = 0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_late_rvalid got %b exp 0", resp_valid); end
        @(negedge clk);
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rst_late_idle got %b exp 01", {resp_valid, req_ready}); end
    endtask

    task automatic test_back_to_back;
        drive_req(1, 3'b000, 32'h01, 32'h000000A5, 5'd0);
        @(negedge clk);
        checks++; if ({mem_req, mem_we, mem_be} !== 6'b110010) begin errors++; $display("FAIL sb_ctrl got %b exp 110010", {mem_req, mem_we, mem_be}); end
        checks++; if (mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", mem_wdata); end
        mem_gnt = 1;
        drive_req(0, 3'b000, 32'h02, 0, 5'd0);
        @(negedge clk);
        mem_gnt = 0;
        checks++; if ({mem_req, req_ready} !== 2'b01) begin errors++; $display("FAIL b2b_idle got %b exp 01", {mem_req, req_ready}); end
        @(negedge clk);
        req_valid = 0;
        checks++; if ({mem_req, mem_we, mem_be} !== 6'b100100) begin errors++; $display("FAIL b2b_lb_ctrl got %b exp 100100", {mem_req, mem_we, mem_be}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL b2b_lb_addr got %h exp 00000000", mem_addr); end
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h00FE0000;
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0;
        checks++; if ({resp_valid, resp_rd} !== {1'b1, 5'd0}) begin errors++; $display("FAIL x0_resp got %b_%0d exp 1_0", resp_valid, resp_rd); end
        checks++; if (resp_rdata !== 32'hFFFFFFFE) begin errors++; $display("FAIL x0_data got %h exp fffffffe", resp_rdata); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extend();
        test_sh();
        test_misalign();
        test_gnt_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
